// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction uses nine's complement of B with the initial carry set to 1.
module bcd_serial_addsub #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sub,
    input  logic [4*NDIG-1:0] A,
    input  logic [4*NDIG-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] S,
    output logic              C,
    output logic              inv
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
    logic            sub_q, sub_d, carry_q, carry_d, inv_acc_q, inv_acc_d;
    logic            c_q, c_d, inv_q, inv_d;

    logic [3:0]      a_dig_s, b_dig_s, bp_s, sum_dig_s;
    logic [4:0]      t_s;
    logic            cout_s, dig_inv_s;
    logic [W-1:0]    acc_next_s;

    // One decimal digit step on the current least-significant operand digits.
    always_comb begin
        a_dig_s   = a_q[3:0];
        b_dig_s   = b_q[3:0];
        bp_s      = sub_q ? (4'd9 - b_dig_s) : b_dig_s;
        t_s       = {1'b0, a_dig_s} + {1'b0, bp_s} + {4'b0000, carry_q};
        dig_inv_s = (a_dig_s > 4'd9) || (b_dig_s > 4'd9);
        if (t_s >= 5'd10) begin
            sum_dig_s = 4'(t_s - 5'd10);
            cout_s    = 1'b1;
        end else begin
            sum_dig_s = t_s[3:0];
            cout_s    = 1'b0;
        end
        // Result digits enter at the top and drift down to their final slot.
        acc_next_s          = acc_q >> 3'd4;
        acc_next_s[W-1 -: 4] = sum_dig_s;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        sub_d     = sub_q;
        carry_d   = carry_q;
        inv_acc_d = inv_acc_q;
        s_d       = s_q;
        c_d       = c_q;
        inv_d     = inv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = A;
                    b_d       = B;
                    sub_d     = sub;
                    carry_d   = sub;
                    acc_d     = '0;
                    idx_d     = '0;
                    inv_acc_d = 1'b0;
                    state_d   = RUN;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                a_d       = a_q >> 3'd4;
                b_d       = b_q >> 3'd4;
                acc_d     = acc_next_s;
                carry_d   = cout_s;
                inv_acc_d = inv_acc_q | dig_inv_s;
                if (idx_q == IW'(NDIG - 1)) begin
                    state_d = DONE;
                    s_d     = acc_next_s;
                    c_d     = cout_s;
                    inv_d   = inv_acc_q | dig_inv_s;
                end else begin
                    idx_d   = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            inv_acc_q <= 1'b0;
            s_q       <= '0;
            c_q       <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            sub_q     <= sub_d;
            carry_q   <= carry_d;
            inv_acc_q <= inv_acc_d;
            s_q       <= s_d;
            c_q       <= c_d;
            inv_q     <= inv_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign C    = c_q;
    assign inv  = inv_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub (NDIG=4): directed table, corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_bcd_serial_addsub;

    localparam int ND  = 4;
    localparam int W   = 4 * ND;
    localparam int MOD = 10000;
    localparam int NV  = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_s = 1'b0;
    logic         sub_s = 1'b0;
    logic [W-1:0] a_s = '0;
    logic [W-1:0] b_s = '0;
    logic         busy_s, done_s, c_s, inv_s;
    logic [W-1:0] s_s;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic         sb;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        logic         iv;
    } vec_t;

    vec_t tbl[NV];

    bcd_serial_addsub #(.NDIG(ND)) dut (
        .clk(clk), .rst(rst), .start(start_s), .sub(sub_s),
        .A(a_s), .B(b_s), .busy(busy_s), .done(done_s),
        .S(s_s), .C(c_s), .inv(inv_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < ND; i++) begin
            r += int'(v[4*i +: 4]) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: decimal arithmetic for valid operands, digit rule otherwise.
    task automatic model(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] s, output logic c, output logic iv);
        int va, vb, d, cy, t, bp;
        iv = 1'b0;
        for (int i = 0; i < ND; i++)
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) iv = 1'b1;
        if (!iv) begin
            va = bcd2int(a);
            vb = bcd2int(b);
            if (!sb) begin
                d = va + vb;
                c = (d >= MOD);
                s = int2bcd(d % MOD);
            end else begin
                d = va - vb;
                c = (d >= 0);
                s = int2bcd(d < 0 ? d + MOD : d);
            end
        end else begin
            cy = sb ? 1 : 0;
            s  = '0;
            for (int i = 0; i < ND; i++) begin
                bp = sb ? ((9 - int'(b[4*i +: 4])) & 15) : int'(b[4*i +: 4]);
                t  = int'(a[4*i +: 4]) + bp + cy;
                if (t >= 10) begin
                    s[4*i +: 4] = 4'((t - 10) & 15);
                    cy = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    cy = 0;
                end
            end
            c = (cy != 0);
        end
    endtask

    task automatic wait_done(output logic [W-1:0] so, output logic co, output logic io, output int lat);
        lat = -1;
        so  = '0;
        co  = 1'b0;
        io  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done_s) begin
                lat = k;
                so  = s_s;
                co  = c_s;
                io  = inv_s;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] so, output logic co, output logic io, output int lat);
        @(negedge clk);
        sub_s   = sb;
        a_s     = a;
        b_s     = b;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        wait_done(so, co, io, lat);
    endtask

    initial begin
        logic [W-1:0] rs, es, aa, bb;
        logic rc, ri, ec, ei, sb, bad;
        int lat, ndone, first, last, highs;

        tbl[0]  = '{1'b0, 16'h1234, 16'h8766, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 16'h0500, 16'h0123, 16'h0377, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 16'h0123, 16'h0500, 16'h9623, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h00A0, 16'h0001, 16'h0101, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 16'h0000, 16'h0001, 16'h9999, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h9999, 16'h9999, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'h4567, 16'h1234, 16'h5801, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'h0001, 16'h0000, 16'h0001, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 16'h0000, 16'h000F, 16'h0001, 1'b1, 1'b1};

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy_s), 32'd0);
        chk("rst_done", 32'(done_s), 32'd0);
        chk("rst_S", 32'(s_s), 32'd0);
        chk("rst_C", 32'(c_s), 32'd0);
        chk("rst_inv", 32'(inv_s), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].sb, tbl[i].a, tbl[i].b, rs, rc, ri, lat);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(ND));
            chk($sformatf("tbl%0d_S", i), 32'(rs), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_C", i), 32'(rc), 32'(tbl[i].c));
            chk($sformatf("tbl%0d_inv", i), 32'(ri), 32'(tbl[i].iv));
        end

        // Second start while busy, with operands changed after acceptance
        @(negedge clk);
        sub_s = 1'b0; a_s = 16'h1234; b_s = 16'h8766; start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        @(negedge clk);
        sub_s = 1'b1; a_s = 16'h0500; b_s = 16'h0123;
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        ndone = 0;
        for (int k = 3; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (done_s) begin
                ndone++;
                chk("busy_in_done", 32'(busy_s), 32'd1);
                chk("busy_S", 32'(s_s), 32'h0000);
                chk("busy_C", 32'(c_s), 32'd1);
            end
        end
        chk("busy_ndone", 32'(ndone), 32'd1);

        // Reset in the middle of an add
        run_op(1'b1, 16'h0500, 16'h0123, rs, rc, ri, lat);
        chk("pre_rst_S", 32'(rs), 32'h0377);
        @(negedge clk);
        sub_s = 1'b0; a_s = 16'h1111; b_s = 16'h2222; start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy_s), 32'd0);
        chk("mid_rst_S", 32'(s_s), 32'd0);
        chk("mid_rst_C", 32'(c_s), 32'd0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done_s) ndone++;
        end
        @(negedge clk);
        rst = 1'b0; sub_s = 1'b0; a_s = 16'h1111; b_s = 16'h2222; start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        chk("rst_no_done", 32'(ndone), 32'd0);
        chk("post_rst_accept", 32'(busy_s), 32'd1);
        wait_done(rs, rc, ri, lat);
        chk("post_rst_lat", 32'(lat), 32'(ND));
        chk("post_rst_S", 32'(rs), 32'h3333);

        // Back-to-back with start held high
        @(negedge clk);
        sub_s = 1'b0; a_s = 16'h0001; b_s = 16'h0002; start_s = 1'b1;
        @(posedge clk);
        #1;
        highs = 0; first = -1; last = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (done_s) begin
                if (first < 0) begin
                    first = k;
                end else begin
                    chk("b2b_spacing", 32'(k - last), 32'(ND + 2));
                end
                last = k;
                highs++;
                chk("b2b_S", 32'(s_s), 32'h0003);
            end
        end
        start_s = 1'b0;
        chk("b2b_first", 32'(first), 32'(ND));
        chk("b2b_pulses", 32'(highs), 32'd3);
        @(posedge clk);
        #1 chk("b2b_idle", 32'(busy_s), 32'd0);

        // Random operations vs reference model
        for (int n = 0; n < 150; n++) begin
            bad = ($urandom_range(0, 7) == 0);
            sb  = 1'($urandom_range(0, 1));
            for (int i = 0; i < ND; i++) begin
                aa[4*i +: 4] = bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
                bb[4*i +: 4] = bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            end
            model(sb, aa, bb, es, ec, ei);
            run_op(sb, aa, bb, rs, rc, ri, lat);
            chk("rnd_lat", 32'(lat), 32'(ND));
            chk("rnd_S", 32'(rs), 32'(es));
            chk("rnd_C", 32'(rc), 32'(ec));
            chk("rnd_inv", 32'(ri), 32'(ei));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
